// File: rtl/usr_tx_pkg.sv
// usr_tx_pkg: shared constants, FSM encoding and keep helpers for the UDP TX user port
package usr_tx_pkg;
  localparam int UDP_HDR_LEN = 8;
  typedef enum logic [2:0] {ST_IDLE, ST_HDR, ST_PAYLOAD, ST_PAD, ST_DROP} state_t;
  function automatic logic [3:0] keep_to_bytes(input logic [7:0] keep);
    keep_to_bytes = 4'd0;
    for (int i = 0; i < 8; i++) keep_to_bytes = keep[i] ? 4'(i + 1) : keep_to_bytes;
  endfunction
endpackage

// File: rtl/usr_tx_keep_mask.sv
// usr_tx_keep_mask: byte count of an input beat and keep mask for the remaining declared length
module usr_tx_keep_mask
  import usr_tx_pkg::*;
(
  input  logic [15:0] rem,
  input  logic [7:0]  keep,
  output logic [3:0]  nb,
  output logic [7:0]  mask,
  output logic        cut,
  output logic        pad_last
);
  assign nb       = keep_to_bytes(keep);
  assign mask     = rem >= 16'd8 ? 8'hFF : ~(8'hFF << rem[2:0]);
  assign cut      = 16'(nb) >= rem;
  assign pad_last = rem <= 16'd8;
endmodule

// File: rtl/usr_udp_tx.sv
// usr_udp_tx: user send port that frames payload to its declared UDP length for the stack
module usr_udp_tx
  import usr_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = 8,
  parameter int MAX_LEN    = 1472,
  parameter int IP_TTL     = 64,
  parameter int IP_DSCP    = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           local_ip,
  input  logic                  s_usr_hdr_valid,
  output logic                  s_usr_hdr_ready,
  input  logic [31:0]           s_usr_dst_ip,
  input  logic [15:0]           s_usr_src_port,
  input  logic [15:0]           s_usr_dst_port,
  input  logic [15:0]           s_usr_length,
  input  logic [DATA_WIDTH-1:0] s_usr_payload_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_usr_payload_axis_tkeep,
  input  logic                  s_usr_payload_axis_tvalid,
  output logic                  s_usr_payload_axis_tready,
  input  logic                  s_usr_payload_axis_tlast,
  input  logic                  s_usr_payload_axis_tuser,
  output logic                  m_udp_hdr_valid,
  input  logic                  m_udp_hdr_ready,
  output logic [5:0]            m_udp_ip_dscp,
  output logic [1:0]            m_udp_ip_ecn,
  output logic [7:0]            m_udp_ip_ttl,
  output logic [31:0]           m_udp_ip_source_ip,
  output logic [31:0]           m_udp_ip_dest_ip,
  output logic [15:0]           m_udp_source_port,
  output logic [15:0]           m_udp_dest_port,
  output logic [15:0]           m_udp_length,
  output logic [15:0]           m_udp_checksum,
  output logic [DATA_WIDTH-1:0] m_udp_payload_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_udp_payload_axis_tkeep,
  output logic                  m_udp_payload_axis_tvalid,
  input  logic                  m_udp_payload_axis_tready,
  output logic                  m_udp_payload_axis_tlast,
  output logic                  m_udp_payload_axis_tuser,
  output logic [31:0]           frames_sent,
  output logic                  err_len,
  output logic                  err_trunc,
  output logic                  err_pad
);
  state_t state, state_n;
  logic [15:0] rem, rem_n;
  logic sticky, sticky_n;
  logic len_bad_n, trunc_n, pad_n;
  logic [3:0] nb;
  logic [7:0] mask;
  logic cut, pad_last, accept, len_ok, in_fire;

  usr_tx_keep_mask u_keep_mask (
    .rem      (rem),
    .keep     (s_usr_payload_axis_tkeep),
    .nb       (nb),
    .mask     (mask),
    .cut      (cut),
    .pad_last (pad_last)
  );

  assign accept          = state == ST_IDLE && s_usr_hdr_valid;
  assign len_ok          = s_usr_length != 16'd0 && s_usr_length <= 16'(MAX_LEN);
  assign in_fire         = s_usr_payload_axis_tvalid && m_udp_payload_axis_tready;
  assign m_udp_hdr_valid = state == ST_HDR;
  assign m_udp_ip_dscp   = 6'(IP_DSCP);
  assign m_udp_ip_ttl    = 8'(IP_TTL);
  assign m_udp_ip_ecn    = 2'd0;
  assign m_udp_checksum  = 16'd0;

  // next state, remaining byte count and the payload stream mux for each state
  always_comb begin
    state_n = state;
    rem_n = rem;
    sticky_n = sticky;
    len_bad_n = 1'b0;
    trunc_n = 1'b0;
    pad_n = 1'b0;
    s_usr_hdr_ready = 1'b0;
    s_usr_payload_axis_tready = 1'b0;
    m_udp_payload_axis_tvalid = 1'b0;
    m_udp_payload_axis_tdata = '0;
    m_udp_payload_axis_tkeep = '0;
    m_udp_payload_axis_tlast = 1'b0;
    m_udp_payload_axis_tuser = 1'b0;
    case (state)
      ST_IDLE: begin
        s_usr_hdr_ready = ~rst;
        if (s_usr_hdr_valid) begin
          state_n = len_ok ? ST_HDR : ST_DROP;
          rem_n = s_usr_length;
          sticky_n = 1'b0;
          len_bad_n = ~len_ok;
        end
      end
      ST_HDR: state_n = m_udp_hdr_ready ? ST_PAYLOAD : ST_HDR;
      ST_PAYLOAD: begin
        s_usr_payload_axis_tready = m_udp_payload_axis_tready;
        m_udp_payload_axis_tvalid = s_usr_payload_axis_tvalid;
        m_udp_payload_axis_tdata = s_usr_payload_axis_tdata;
        m_udp_payload_axis_tkeep = cut ? s_usr_payload_axis_tkeep & mask : s_usr_payload_axis_tkeep;
        m_udp_payload_axis_tlast = cut;
        m_udp_payload_axis_tuser = cut & (sticky | s_usr_payload_axis_tuser);
        if (in_fire) begin
          sticky_n = sticky | s_usr_payload_axis_tuser;
          rem_n = rem - 16'(nb);
          if (cut) begin
            state_n = s_usr_payload_axis_tlast ? ST_IDLE : ST_DROP;
            trunc_n = !(16'(nb) == rem && s_usr_payload_axis_tlast);
          end else if (s_usr_payload_axis_tlast) begin
            state_n = ST_PAD;
            pad_n = 1'b1;
          end
        end
      end
      ST_PAD: begin
        m_udp_payload_axis_tvalid = 1'b1;
        m_udp_payload_axis_tkeep = mask;
        m_udp_payload_axis_tlast = pad_last;
        m_udp_payload_axis_tuser = pad_last;
        if (m_udp_payload_axis_tready) begin
          rem_n = rem - 16'd8;
          state_n = pad_last ? ST_IDLE : ST_PAD;
        end
      end
      ST_DROP: begin
        s_usr_payload_axis_tready = 1'b1;
        state_n = s_usr_payload_axis_tvalid && s_usr_payload_axis_tlast ? ST_IDLE : ST_DROP;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // FSM, counters and one-cycle error pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      rem <= '0;
      sticky <= 1'b0;
      frames_sent <= '0;
      err_len <= 1'b0;
      err_trunc <= 1'b0;
      err_pad <= 1'b0;
    end else begin
      state <= state_n;
      rem <= rem_n;
      sticky <= sticky_n;
      err_len <= len_bad_n;
      err_trunc <= trunc_n;
      err_pad <= pad_n;
      if (m_udp_payload_axis_tvalid && m_udp_payload_axis_tready && m_udp_payload_axis_tlast)
        frames_sent <= frames_sent + 32'd1;
    end
  end

  // header fields captured at descriptor accept and held through the header handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_udp_ip_source_ip <= '0;
      m_udp_ip_dest_ip <= '0;
      m_udp_source_port <= '0;
      m_udp_dest_port <= '0;
      m_udp_length <= '0;
    end else if (accept) begin
      m_udp_ip_source_ip <= local_ip;
      m_udp_ip_dest_ip <= s_usr_dst_ip;
      m_udp_source_port <= s_usr_src_port;
      m_udp_dest_port <= s_usr_dst_port;
      m_udp_length <= s_usr_length + 16'(UDP_HDR_LEN);
    end
  end
endmodule

// File: tb/tb_usr_udp_tx.sv
// tb_usr_udp_tx: randomized byte-stream scoreboard check of the UDP TX user port
module tb_usr_udp_tx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] local_ip = 32'hC0A8_0101;
  logic s_usr_hdr_valid = 1'b0, s_usr_hdr_ready;
  logic [31:0] s_usr_dst_ip = '0;
  logic [15:0] s_usr_src_port = '0, s_usr_dst_port = '0, s_usr_length = '0;
  logic [63:0] s_tdata = '0;
  logic [7:0] s_tkeep = '0;
  logic s_tvalid = 1'b0, s_tready, s_tlast = 1'b0, s_tuser = 1'b0;
  logic m_udp_hdr_valid, m_udp_hdr_ready = 1'b0;
  logic [5:0] m_dscp;
  logic [1:0] m_ecn;
  logic [7:0] m_ttl;
  logic [31:0] m_src_ip, m_dst_ip, frames_sent;
  logic [15:0] m_sp, m_dp, m_len, m_cks;
  logic [63:0] m_tdata;
  logic [7:0] m_tkeep;
  logic m_tvalid, m_tready = 1'b0, m_tlast, m_tuser;
  logic err_len, err_trunc, err_pad;

  usr_udp_tx dut (
    .clk(clk), .rst(rst), .local_ip(local_ip),
    .s_usr_hdr_valid(s_usr_hdr_valid), .s_usr_hdr_ready(s_usr_hdr_ready),
    .s_usr_dst_ip(s_usr_dst_ip), .s_usr_src_port(s_usr_src_port),
    .s_usr_dst_port(s_usr_dst_port), .s_usr_length(s_usr_length),
    .s_usr_payload_axis_tdata(s_tdata), .s_usr_payload_axis_tkeep(s_tkeep),
    .s_usr_payload_axis_tvalid(s_tvalid), .s_usr_payload_axis_tready(s_tready),
    .s_usr_payload_axis_tlast(s_tlast), .s_usr_payload_axis_tuser(s_tuser),
    .m_udp_hdr_valid(m_udp_hdr_valid), .m_udp_hdr_ready(m_udp_hdr_ready),
    .m_udp_ip_dscp(m_dscp), .m_udp_ip_ecn(m_ecn), .m_udp_ip_ttl(m_ttl),
    .m_udp_ip_source_ip(m_src_ip), .m_udp_ip_dest_ip(m_dst_ip),
    .m_udp_source_port(m_sp), .m_udp_dest_port(m_dp),
    .m_udp_length(m_len), .m_udp_checksum(m_cks),
    .m_udp_payload_axis_tdata(m_tdata), .m_udp_payload_axis_tkeep(m_tkeep),
    .m_udp_payload_axis_tvalid(m_tvalid), .m_udp_payload_axis_tready(m_tready),
    .m_udp_payload_axis_tlast(m_tlast), .m_udp_payload_axis_tuser(m_tuser),
    .frames_sent(frames_sent), .err_len(err_len), .err_trunc(err_trunc), .err_pad(err_pad)
  );

  typedef struct {
    int len;
    logic [31:0] dst;
    logic [15:0] sp;
    logic [15:0] dp;
    logic user;
  } exp_t;

  int n_cmp = 0, n_bad = 0;
  exp_t hq[$];
  exp_t fq[$];
  byte unsigned xb[$];
  byte unsigned gb[$];
  int nbq[$];
  bit usq[$];
  int exp_len_err = 0, exp_trunc = 0, exp_pad = 0, legal_frames = 0;
  int got_len_err = 0, got_trunc = 0, got_pad = 0;
  logic mon_en = 1'b1, rnd_rdy = 1'b0;
  logic [7:0] last_keep = '0;
  logic hv_stall = 1'b0, tv_stall = 1'b0;
  logic [63:0] ph = '0, pd = '0;
  logic [9:0] pc = '0;
  exp_t me;
  int mis;
  byte unsigned mb;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic give_up(input string tag);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: wait bound expired", tag);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "aborted");
  endtask

  // ready generators for the stack side
  initial forever begin
    @(posedge clk);
    #1;
    m_udp_hdr_ready = rnd_rdy ? 1'($urandom % 2) : 1'b1;
    m_tready = rnd_rdy ? 1'($urandom % 2) : 1'b1;
  end

  // monitor: error pulse counting, stall stability, header and byte-stream scoreboard
  always @(negedge clk) begin
    got_len_err += int'(err_len);
    got_trunc += int'(err_trunc);
    got_pad += int'(err_pad);
    if (mon_en) begin
      if (hv_stall) chk("hdr_hold", {m_udp_hdr_valid, m_len, m_dp, m_sp}, ph);
      hv_stall = m_udp_hdr_valid && !m_udp_hdr_ready;
      ph = {m_udp_hdr_valid, m_len, m_dp, m_sp};
      if (tv_stall) begin
        chk("pay_hold_data", m_tdata, pd);
        chk("pay_hold_ctl", 64'({m_tvalid, m_tkeep, m_tlast}), 64'(pc));
      end
      tv_stall = m_tvalid && !m_tready;
      pd = m_tdata;
      pc = {m_tvalid, m_tkeep, m_tlast};
      if (m_udp_hdr_valid && m_udp_hdr_ready) begin
        if (hq.size() == 0) chk("unexpected_hdr", 64'(m_len), 64'(0));
        else begin
          me = hq.pop_front();
          chk("hdr_length", 64'(m_len), 64'(me.len + 8));
          chk("hdr_dst_ip", 64'(m_dst_ip), 64'(me.dst));
          chk("hdr_src_ip", 64'(m_src_ip), 64'(local_ip));
          chk("hdr_ports", 64'({m_sp, m_dp}), 64'({me.sp, me.dp}));
          chk("hdr_ttl_dscp_ecn", 64'({m_ttl, m_dscp, m_ecn}), 64'({8'd64, 6'd0, 2'd0}));
          chk("hdr_checksum", 64'(m_cks), 64'(0));
        end
      end
      if (m_tvalid && m_tready) begin
        for (int i = 0; i < 8; i++) if (m_tkeep[i]) gb.push_back(m_tdata[8*i +: 8]);
        if (m_tlast) begin
          last_keep = m_tkeep;
          if (fq.size() == 0) chk("unexpected_frame", 64'(gb.size()), 64'(0));
          else begin
            me = fq.pop_front();
            chk("pay_len", 64'(gb.size()), 64'(me.len));
            mis = 0;
            for (int i = 0; i < me.len; i++) begin
              mb = xb.size() > 0 ? xb.pop_front() : 8'd0;
              if (i >= gb.size() || gb[i] != mb) mis++;
            end
            chk("pay_data_bytes_wrong", 64'(mis), 64'(0));
            chk("pay_tuser", 64'(m_tuser), 64'(me.user));
          end
          gb.delete();
        end
      end
    end
  end

  task automatic send_frame(input int len);
    int total = 0, cum = 0, k;
    bit u = 1'b0;
    byte unsigned bytes[$];
    logic [63:0] dat[$];
    logic [63:0] d;
    exp_t e;
    foreach (nbq[i]) begin
      d = {$urandom, $urandom};
      dat.push_back(d);
      for (int j = 0; j < nbq[i]; j++) bytes.push_back(d[8*j +: 8]);
      total += nbq[i];
    end
    e.dst = $urandom;
    e.sp = 16'($urandom);
    e.dp = 16'($urandom);
    e.len = len;
    if (len < 1 || len > 1472) exp_len_err++;
    else begin
      foreach (nbq[i]) if (cum < len) begin
        u |= usq[i];
        cum += nbq[i];
      end
      if (total < len) begin
        u = 1'b1;
        exp_pad++;
      end else if (total > len) exp_trunc++;
      for (int i = 0; i < len; i++) xb.push_back(i < total ? bytes[i] : 8'd0);
      e.user = u;
      hq.push_back(e);
      fq.push_back(e);
      legal_frames++;
    end
    @(posedge clk);
    #1;
    s_usr_hdr_valid = 1'b1;
    s_usr_length = 16'(len);
    s_usr_dst_ip = e.dst;
    s_usr_src_port = e.sp;
    s_usr_dst_port = e.dp;
    for (k = 0; k < 4000; k++) begin
      @(negedge clk);
      if (s_usr_hdr_ready) break;
    end
    if (k == 4000) give_up("hdr_accept_timeout");
    @(posedge clk);
    #1;
    s_usr_hdr_valid = 1'b0;
    foreach (nbq[i]) begin
      if (rnd_rdy && $urandom % 4 == 0) begin
        s_tvalid = 1'b0;
        @(posedge clk);
        #1;
      end
      s_tvalid = 1'b1;
      s_tdata = dat[i];
      s_tkeep = 8'((9'd1 << nbq[i]) - 9'd1);
      s_tlast = i == nbq.size() - 1;
      s_tuser = usq[i];
      for (k = 0; k < 4000; k++) begin
        @(negedge clk);
        if (s_tready) break;
      end
      if (k == 4000) give_up("beat_accept_timeout");
      @(posedge clk);
      #1;
    end
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
    s_tuser = 1'b0;
  endtask

  task automatic drain();
    int k;
    for (k = 0; k < 4000; k++) begin
      @(negedge clk);
      if (fq.size() == 0 && hq.size() == 0 && s_usr_hdr_ready) break;
    end
    if (k == 4000) give_up("drain_timeout");
    repeat (3) @(negedge clk);
  endtask

  task automatic fill(input int n, input int total);
    int r = total, b;
    nbq.delete();
    usq.delete();
    for (int i = 0; i < n; i++) begin
      nbq.push_back(8);
      usq.push_back(1'b0);
    end
    while (r > 0 && n == 0) begin
      b = $urandom_range(1, 8);
      b = b > r ? r : b;
      nbq.push_back(b);
      usq.push_back($urandom % 8 == 0);
      r -= b;
    end
  endtask

  initial begin
    int len, total, m;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hdr_ready", 64'(s_usr_hdr_ready), 64'(0));
    chk("rst_hdr_valid", 64'(m_udp_hdr_valid), 64'(0));
    chk("rst_tvalid_tready", 64'({m_tvalid, s_tready, m_tlast}), 64'(0));
    chk("rst_ttl_dscp", 64'({m_ttl, m_dscp}), 64'({8'd64, 6'd0}));
    chk("rst_frames_len", 64'({frames_sent, m_len}), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;

    fill(2, 0); send_frame(16); drain();
    chk("t1_frames_sent", 64'(frames_sent), 64'(1));
    chk("t1_last_keep", 64'(last_keep), 64'(8'hFF));

    fill(2, 0); send_frame(10); drain();
    chk("t2_last_keep", 64'(last_keep), 64'(8'h03));
    chk("t2_err_trunc", 64'(got_trunc), 64'(1));

    fill(0, 0); nbq = '{8, 4}; usq = '{1'b0, 1'b0}; send_frame(20); drain();
    chk("t3_last_keep", 64'(last_keep), 64'(8'hFF));
    chk("t3_err_pad", 64'(got_pad), 64'(1));

    fill(3, 0); send_frame(0);
    fill(3, 0); send_frame(1473); drain();
    chk("t4_err_len", 64'(got_len_err), 64'(2));
    chk("t4_frames_sent", 64'(frames_sent), 64'(3));

    fill(0, 0); nbq = '{1}; usq = '{1'b1}; send_frame(1); drain();
    chk("len1_last_keep", 64'(last_keep), 64'(8'h01));
    fill(184, 0); send_frame(1472); drain();
    fill(0, 0); nbq = '{8, 8, 3}; usq = '{1'b0, 1'b1, 1'b0}; send_frame(9); drain();

    rnd_rdy = 1'b1;
    for (int f = 0; f < 100; f++) begin
      if ($urandom % 10 == 0) begin
        len = ($urandom % 2) ? 0 : 1473 + int'($urandom % 100);
        total = $urandom_range(1, 24);
      end else begin
        len = $urandom_range(1, 64);
        m = $urandom % 3;
        total = m == 0 ? len : m == 1 ? $urandom_range(1, len) : len + $urandom_range(1, 20);
      end
      fill(0, total);
      send_frame(len);
    end
    rnd_rdy = 1'b0;
    drain();
    chk("tot_err_len", 64'(got_len_err), 64'(exp_len_err));
    chk("tot_err_trunc", 64'(got_trunc), 64'(exp_trunc));
    chk("tot_err_pad", 64'(got_pad), 64'(exp_pad));
    chk("tot_frames_sent", 64'(frames_sent), 64'(legal_frames));

    mon_en = 1'b0;
    @(posedge clk);
    #1;
    s_usr_hdr_valid = 1'b1;
    s_usr_length = 16'd32;
    @(posedge clk);
    #1;
    s_usr_hdr_valid = 1'b0;
    s_tvalid = 1'b1;
    s_tdata = {$urandom, $urandom};
    s_tkeep = 8'hFF;
    begin
      int k;
      for (k = 0; k < 100; k++) begin
        @(negedge clk);
        if (s_tready) break;
      end
      if (k == 100) give_up("t6_beat1_timeout");
    end
    @(posedge clk);
    #1;
    s_tdata = {$urandom, $urandom};
    @(negedge clk);
    chk("t6_beat2_presented", 64'(m_tvalid), 64'(1));
    rst = 1'b1;
    #1;
    chk("t6_rst_tvalid_tlast", 64'({m_tvalid, m_tlast, m_udp_hdr_valid}), 64'(0));
    chk("t6_rst_readies", 64'({s_tready, s_usr_hdr_ready}), 64'(0));
    chk("t6_rst_frames", 64'(frames_sent), 64'(0));
    chk("t6_rst_ttl", 64'(m_ttl), 64'(64));
    s_tvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    gb.delete();
    hq.delete();
    fq.delete();
    xb.delete();
    hv_stall = 1'b0;
    tv_stall = 1'b0;
    mon_en = 1'b1;
    fill(1, 0); send_frame(8); drain();
    chk("t6_frames_sent", 64'(frames_sent), 64'(1));
    chk("t6_last_keep", 64'(last_keep), 64'(8'hFF));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
